// File: rtl/signed_seq_mult.sv
// rtl/signed_seq_mult.sv - sequential shift-add signed multiplier, sign + magnitude result
module signed_seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic           sign,
    output logic [2*N-2:0] mag
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_ma;
    logic [N-1:0]   r_mb;
    logic           r_psign;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_sign;
    logic [2*N-2:0] r_mag;

    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [2*N-1:0] w_addend;
    logic [2*N-1:0] w_acc_next;
    logic           w_last;

    // |-2^(N-1)| wraps back to 2^(N-1), which is exact as an N-bit unsigned value
    assign w_abs_a    = a[N-1] ? (~a + 1'b1) : a;
    assign w_abs_b    = b[N-1] ? (~b + 1'b1) : b;
    assign w_addend   = {{N{1'b0}}, r_ma} << r_cnt;
    assign w_acc_next = r_mb[0] ? (r_acc + w_addend) : r_acc;
    assign w_last     = (r_cnt == CW'(N - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ma    <= '0;
            r_mb    <= '0;
            r_psign <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sign  <= 1'b0;
            r_mag   <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ma    <= w_abs_a;
                        r_mb    <= w_abs_b;
                        r_psign <= a[N-1] ^ b[N-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    // Result registers load only here, so they hold between operations
                    if (w_last) begin
                        r_mag  <= w_acc_next[2*N-2:0];
                        r_sign <= r_psign & (|w_acc_next);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sign = r_sign;
    assign mag  = r_mag;
endmodule

// File: tb/tb_signed_seq_mult.sv
// tb/tb_signed_seq_mult.sv - scoreboard bench for signed_seq_mult
module tb_signed_seq_mult;
    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic           sign;
    logic [2*N-2:0] mag;

    int tests = 0;
    int fails = 0;
    logic [2*N-1:0] sb_q[$];

    signed_seq_mult #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sign  (sign),
        .mag   (mag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got sign=%0d mag=%0d with no operation outstanding", sign, mag);
            end else begin
                logic [2*N-1:0] exp_v;
                exp_v = sb_q.pop_front();
                if ({sign, mag} !== exp_v) begin
                    fails++;
                    $display("FAIL result: got sign=%0d mag=%0d expected sign=%0d mag=%0d",
                             sign, mag, exp_v[2*N-1], exp_v[2*N-2:0]);
                end
            end
        end
    end

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < N + 6) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic do_mult(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                           input int em, input logic es, input string name);
        int k;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        sb_q.push_back({es, 15'(em)});
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'h5A; b = 8'hA5;
        chk({name, "_busy_rise"}, int'(busy), 1);
        wait_done(k);
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no done after %0d edges, required done after %0d", name, k, N);
        end else begin
            chk({name, "_latency"}, k, N);
        end
        @(posedge clk); #1;
        chk({name, "_done_low"}, int'(done), 0);
        chk({name, "_busy_low"}, int'(busy), 0);
        chk({name, "_mag_hold"}, int'(mag), em);
        chk({name, "_sign_hold"}, int'(sign), int'(es));
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sign", int'(sign), 0);
        chk("rst_mag", int'(mag), 0);
        @(negedge clk); rst = 1'b0;

        do_mult(8'd7,   8'd6,   42,    1'b0, "7x6");
        do_mult(8'hFB,  8'd3,   15,    1'b1, "m5x3");
        do_mult(8'h80,  8'h80,  16384, 1'b0, "m128xm128");
        do_mult(8'd127, 8'h80,  16256, 1'b1, "127xm128");
        do_mult(8'd0,   8'hF7,  0,     1'b0, "0xm9");

        // Starts during CALC and DONE must be ignored
        @(negedge clk);
        a = 8'd2; b = 8'd3; start = 1'b1;
        sb_q.push_back({1'b0, 15'd6});
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        if (!done) begin
            tests++; fails++;
            $display("FAIL ovl_timeout: got no done, required one done with mag=6");
        end
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ovl_start_in_done_ignored", int'(busy), 0);
        do_mult(8'd9, 8'd9, 81, 1'b0, "9x9");

        // Reset in the middle of an operation discards it
        @(negedge clk);
        a = 8'hF6; b = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_mag", int'(mag), 0);
        chk("midrst_sign", int'(sign), 0);
        repeat (N + 4) @(negedge clk);
        do_mult(8'd3, 8'd3, 9, 1'b0, "3x3");

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
